// File: rtl/pe2ddr_sched_if.sv
// -----------------------------------------------------------------------------
// pe2ddr_sched_if
// Bundles the three handshakes that the write-back scheduler sits between:
//   job_*      : transfer job from the layer controller (valid/ready)
//   conf_*,
//   pe_start,
//   pe_done    : configuration, start pulse and completion of the PE datapath
//   ddr_aw_*   : DDR write-address request channel (valid/ready)
// Modports:
//   master : the scheduler side (accepts jobs, drives the datapath and AW)
//   slave  : the environment side (controller, datapath and DDR)
// -----------------------------------------------------------------------------
interface pe2ddr_sched_if #(
  parameter int DDR_AW = 32
);
  logic              job_valid;
  logic              job_ready;
  logic [3:0]        job_layer_type;
  logic [1:0]        job_trans_type;
  logic [7:0]        job_trans_num;
  logic [3:0]        job_grp_mask;
  logic [DDR_AW-1:0] job_ddr_addr;

  logic [3:0]        conf_layer_type;
  logic [1:0]        conf_trans_type;
  logic [7:0]        conf_trans_num;
  logic [1:0]        conf_grp_sel;
  logic              pe_start;
  logic              pe_done;

  logic [DDR_AW-1:0] ddr_aw_addr;
  logic [7:0]        ddr_aw_len;
  logic              ddr_aw_valid;
  logic              ddr_aw_ready;

  modport master (
    input  job_valid, job_layer_type, job_trans_type, job_trans_num,
           job_grp_mask, job_ddr_addr, pe_done, ddr_aw_ready,
    output job_ready, conf_layer_type, conf_trans_type, conf_trans_num,
           conf_grp_sel, pe_start, ddr_aw_addr, ddr_aw_len, ddr_aw_valid
  );

  modport slave (
    output job_valid, job_layer_type, job_trans_type, job_trans_num,
           job_grp_mask, job_ddr_addr, pe_done, ddr_aw_ready,
    input  job_ready, conf_layer_type, conf_trans_type, conf_trans_num,
           conf_grp_sel, pe_start, ddr_aw_addr, ddr_aw_len, ddr_aw_valid
  );
endinterface

// File: rtl/pe2ddr_sched.sv
// -----------------------------------------------------------------------------
// pe2ddr_sched
// Sequences the PE-result-to-DDR write-back path. A job selects a set of
// accumulator groups; for each selected group (lowest index first) the
// scheduler issues one DDR write-address burst, pulses the datapath start with
// the group index, and waits for the datapath done. A watchdog aborts the job
// if the datapath hangs.
// Ports:
//   clk, rst    : clock, asynchronous active-high reset
//   bus         : job / datapath / DDR AW handshakes (pe2ddr_sched_if.master)
//   busy        : FSM not in IDLE
//   job_done    : one-cycle pulse at the end of every accepted job
//   err_timeout : sticky watchdog error, cleared only by rst
// -----------------------------------------------------------------------------
module pe2ddr_sched #(
  parameter int DDR_AW      = 32,
  parameter int BEAT_BYTES  = 64,
  parameter int TIMEOUT_CYC = 4096
) (
  input  logic           clk,
  input  logic           rst,
  pe2ddr_sched_if.master bus,
  output logic           busy,
  output logic           job_done,
  output logic           err_timeout
);

  localparam int               CNT_W   = $clog2(TIMEOUT_CYC + 1);
  localparam logic [CNT_W-1:0] WD_LAST = CNT_W'(TIMEOUT_CYC - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD, ADDR, START, WAIT, NEXT, DONE
  } state_t;

  state_t            state, state_nxt;

  logic [3:0]        layer_r;
  logic [1:0]        trans_type_r;
  logic [7:0]        trans_num_r;
  logic [3:0]        grp_mask_r;
  logic [DDR_AW-1:0] addr_r;
  logic [3:0]        pend_r;
  logic [1:0]        grp_sel_r;
  logic [CNT_W-1:0]  wd_cnt;
  logic              err_r;

  logic [3:0]        load_mask;
  logic [3:0]        pend_clr;
  logic [DDR_AW-1:0] step;
  logic              wd_expire;

  function automatic logic [1:0] lowest_set(input logic [3:0] m);
    logic [1:0] idx;
    idx = 2'd0;
    if (m[0])      idx = 2'd0;
    else if (m[1]) idx = 2'd1;
    else if (m[2]) idx = 2'd2;
    else if (m[3]) idx = 2'd3;
    return idx;
  endfunction

  // Non-grouped layers run a single pass on group 0; the datapath sums all
  // groups itself in that mode.
  assign load_mask = layer_r[0] ? grp_mask_r : 4'b0001;
  assign pend_clr  = pend_r & ~(4'b0001 << grp_sel_r);
  // Address arithmetic deliberately stays in DDR_AW bits so it wraps silently.
  assign step      = DDR_AW'(trans_num_r) * DDR_AW'(BEAT_BYTES);
  // A done arriving on the last watchdog cycle still counts as success.
  assign wd_expire = (wd_cnt == WD_LAST) && !bus.pe_done;

  assign bus.conf_layer_type = layer_r;
  assign bus.conf_trans_type = trans_type_r;
  assign bus.conf_trans_num  = trans_num_r;
  assign bus.conf_grp_sel    = grp_sel_r;
  assign bus.ddr_aw_addr     = addr_r;
  assign bus.ddr_aw_len      = trans_num_r;
  assign err_timeout         = err_r;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt        = state;
    bus.job_ready    = 1'b0;
    bus.ddr_aw_valid = 1'b0;
    bus.pe_start     = 1'b0;
    job_done         = 1'b0;
    busy             = (state != IDLE);
    case (state)
      IDLE: begin
        bus.job_ready = 1'b1;
        if (bus.job_valid) state_nxt = LOAD;
      end
      LOAD: begin
        if (load_mask == 4'd0 || trans_num_r == 8'd0) state_nxt = DONE;
        else                                          state_nxt = ADDR;
      end
      ADDR: begin
        bus.ddr_aw_valid = 1'b1;
        if (bus.ddr_aw_ready) state_nxt = START;
      end
      START: begin
        bus.pe_start = 1'b1;
        state_nxt    = WAIT;
      end
      WAIT: begin
        if (bus.pe_done)    state_nxt = NEXT;
        else if (wd_expire) state_nxt = DONE;
      end
      NEXT: begin
        if (pend_clr != 4'd0) state_nxt = ADDR;
        else                  state_nxt = DONE;
      end
      DONE: begin
        job_done  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      layer_r      <= '0;
      trans_type_r <= '0;
      trans_num_r  <= '0;
      grp_mask_r   <= '0;
      addr_r       <= '0;
      pend_r       <= '0;
      grp_sel_r    <= '0;
      wd_cnt       <= '0;
      err_r        <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (bus.job_valid) begin
            layer_r      <= bus.job_layer_type;
            trans_type_r <= bus.job_trans_type;
            trans_num_r  <= bus.job_trans_num;
            grp_mask_r   <= bus.job_grp_mask;
            addr_r       <= bus.job_ddr_addr;
            // Group index is settled at accept so conf_* hold still from LOAD on.
            grp_sel_r    <= lowest_set(bus.job_layer_type[0] ? bus.job_grp_mask
                                                             : 4'b0001);
          end
        end
        LOAD:  pend_r <= load_mask;
        START: wd_cnt <= '0;
        WAIT: begin
          wd_cnt <= wd_cnt + CNT_W'(1);
          if (wd_expire) err_r <= 1'b1;
        end
        NEXT: begin
          pend_r <= pend_clr;
          addr_r <= addr_r + step;
          if (pend_clr != 4'd0) grp_sel_r <= lowest_set(pend_clr);
        end
        default: ;
      endcase
    end
  end

endmodule

// File: doc/pe2ddr_sched.md
Name: pe2ddr_sched

Overview:
- Sequences the PE-result-to-DDR write-back datapath.
- Accepts transfer jobs from the layer controller and iterates over the selected accumulator groups.
- Per pass: issues one DDR write-address request, pulses the datapath start with its configuration, then waits for the datapath's done.
- Signals job completion; a watchdog flags a hung datapath.

Parameters:
- DDR_AW, 32, DDR byte-address width.
- BEAT_BYTES, 64, bytes per DDR data beat (DDR_W/8).
- TIMEOUT_CYC, 4096, max cycles in WAIT before the error is raised.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- job_valid  in  1  job offered
- job_ready  out  1  scheduler can accept a job
- job_layer_type  in  4  layer type; bit0=1 means per-group transfer
- job_trans_type  in  2  transfer type, passed to the datapath
- job_trans_num  in  8  DDR beats per pass
- job_grp_mask  in  4  groups to transfer (used only when layer_type[0]=1)
- job_ddr_addr  in  DDR_AW  DDR byte address of the first pass
- conf_layer_type  out  4  registered datapath config
- conf_trans_type  out  2  registered datapath config
- conf_trans_num  out  8  registered datapath config
- conf_grp_sel  out  2  group index for the current pass
- pe_start  out  1  one-cycle start pulse to the datapath
- pe_done  in  1  datapath pass complete (pulse)
- ddr_aw_addr  out  DDR_AW  write burst address
- ddr_aw_len  out  8  beats in the burst, equal to trans_num
- ddr_aw_valid  out  1  address request
- ddr_aw_ready  in  1  address accepted
- busy  out  1  high whenever the FSM is not in IDLE
- job_done  out  1  one-cycle pulse when a job finishes
- err_timeout  out  1  sticky watchdog error

Behaviour:
- Reset (async, rst=1):
  - FSM goes to IDLE.
  - All outputs are 0, except job_ready=1.
  - err_timeout clears.
  - Internal registers clear.
  - Reset mid-job abandons the job; no job_done is issued.
- States: IDLE, LOAD, ADDR, START, WAIT, NEXT, DONE.
- IDLE:
  - job_ready=1.
  - On job_valid&job_ready, latch all job_* fields and go to LOAD.
- LOAD: build the pending-group mask.
  - layer_type[0]=0: mask = 4'b0001; conf_grp_sel stays 0 and the group datapath sums all groups.
  - layer_type[0]=1: mask = job_grp_mask.
  - If the mask is 0 or trans_num=0, go to DONE (no pass, no AW, no pe_start).
  - Otherwise conf_grp_sel = index of the lowest set bit; go to ADDR.
- ADDR:
  - ddr_aw_valid=1 and held while in ADDR.
  - ddr_aw_addr/len stay stable until ddr_aw_valid&ddr_aw_ready.
  - On the handshake, go to START.
- START:
  - pe_start=1 for exactly this cycle.
  - conf_* are stable from LOAD through the end of WAIT.
  - Go to WAIT.
- WAIT:
  - Watchdog counter starts at 0 on entry.
  - On pe_done, go to NEXT.
  - If the count reaches TIMEOUT_CYC-1 without pe_done: set err_timeout, go to DONE (job aborted; job_done still pulses).
  - pe_done outside WAIT is ignored.
  - pe_done in the same cycle as the timeout: pe_done wins, no error.
- NEXT:
  - Clear the current group's bit.
  - ddr_addr += trans_num*BEAT_BYTES, computed in DDR_AW bits; wraps modulo 2^DDR_AW with no error.
  - If remaining mask ≠0: conf_grp_sel = next lowest set bit, go to ADDR. Else go to DONE.
- DONE:
  - job_done=1 for one cycle.
  - Go to IDLE; the next job can be accepted in the following cycle.
- Handshake:
  - job_ready is combinational from state only (IDLE).
  - No job is accepted while busy.
- Latency, ideal case (job accept to first pe_start): accept → LOAD → ADDR (aw_ready=1) → START, so pe_start is asserted 3 cycles after the accept edge.
- Per-pass overhead: 3 cycles plus datapath time.

Test Plan:
1. Conv job: layer_type=0, trans_type=1, trans_num=16, addr=0x1000, aw_ready=1, pe_done 20 cycles after start → one AW (addr 0x1000, len 16), one pe_start with grp_sel=0, then job_done.
2. Grouped job: layer_type=1, grp_mask=4'b1010, trans_num=8, addr=0x2000 → passes with grp_sel 1 then 3; AW addrs 0x2000 then 0x2200; 2 pe_start pulses, 1 job_done.
3. Backpressure: aw_ready low for 10 cycles → aw_valid/addr held stable, no pe_start until the handshake.
4. Empty job: grp_mask=0 (layer_type=1), or trans_num=0 → job_done 2 cycles after accept; no AW, no pe_start.
5. Watchdog: TIMEOUT_CYC=64, pe_done never arrives → err_timeout=1 and a job_done pulse after 64 WAIT cycles; err_timeout stays 1 until rst.
6. Async rst asserted in WAIT mid-cycle → outputs clear immediately (job_ready=1, busy=0); a subsequent job runs normally.
